// File: rtl/matmul_seq_pkg.sv
// ============================================================================
// Module      : matmul_seq_pkg
// Description : Shared types and helpers for the sequential matrix multiplier
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package matmul_seq_pkg;

  // Engine control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } matmul_state_e;

  // Result element width: full product plus headroom for N partial sums
  function automatic int acc_width(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  // Flat row-major element index of (row, col) in an n x n matrix
  function automatic int elem_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

  // Lowest bit of element (row, col) in a packed row-major matrix
  function automatic int elem_lsb(input int row, input int col, input int n, input int w);
    return elem_idx(row, col, n) * w;
  endfunction

endpackage : matmul_seq_pkg

`default_nettype wire

// File: rtl/matmul_seq_if.sv
// ============================================================================
// Module      : matmul_seq_if
// Description : Operand/result handshake bundle for matmul_seq
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_seq_if
  import matmul_seq_pkg::*;
#(
  parameter int N         = 2,
  parameter int DataWidth = 8,
  parameter int AccWidth  = acc_width(N, DataWidth)
);

  logic                         in_valid_i;
  logic                         in_ready_o;
  logic [N*N*DataWidth-1:0]     operand_a_i;
  logic [N*N*DataWidth-1:0]     operand_b_i;
  logic                         signed_i;
  logic                         accumulate_i;
  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [N*N*AccWidth-1:0]      result_o;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid_i,
    input  in_ready_o,
    output operand_a_i,
    output operand_b_i,
    output signed_i,
    output accumulate_i,
    input  out_valid_o,
    output out_ready_i,
    input  result_o
  );

  // Engine side
  modport slave (
    input  in_valid_i,
    output in_ready_o,
    input  operand_a_i,
    input  operand_b_i,
    input  signed_i,
    input  accumulate_i,
    output out_valid_o,
    input  out_ready_i,
    output result_o
  );

endinterface : matmul_seq_if

`default_nettype wire

// File: rtl/matmul_seq_mac.sv
// ============================================================================
// Module      : matmul_mac
// Description : One multiply-accumulate lane: DataWidth x DataWidth product,
//               sign/zero-extended and added into an AccWidth accumulator
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_mac #(
  parameter int DataWidth = 8,
  parameter int AccWidth  = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic                 signed_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [AccWidth-1:0]  seed_i,
  output logic [AccWidth-1:0]  sum_o
);

  logic [2*DataWidth-1:0] ext_a;
  logic [2*DataWidth-1:0] ext_b;
  logic [2*DataWidth-1:0] prod;
  logic [AccWidth-1:0]    prod_ext;
  logic [AccWidth-1:0]    base;
  logic [AccWidth-1:0]    acc_q;

  // Single multiplier: operands are pre-extended to 2*DataWidth so the low
  // half of the product is exact for both signed and unsigned elements
  always_comb begin
    ext_a    = signed_i ? {{DataWidth{a_i[DataWidth-1]}}, a_i} : {{DataWidth{1'b0}}, a_i};
    ext_b    = signed_i ? {{DataWidth{b_i[DataWidth-1]}}, b_i} : {{DataWidth{1'b0}}, b_i};
    prod     = ext_a * ext_b;
    prod_ext = signed_i ? AccWidth'($signed(prod)) : AccWidth'(prod);
    base     = load_i ? seed_i : acc_q;
    sum_o    = base + prod_ext;
  end

  // Running partial sum; the first step of each row restarts from the seed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum_o;
    end
  end

endmodule : matmul_mac

`default_nettype wire

// File: rtl/matmul_seq.sv
// ============================================================================
// Module      : matmul_seq
// Description : Sequential N x N integer matrix multiplier. One row of N MAC
//               lanes is reused for N*N steps; supports signed/unsigned and
//               accumulate-into-previous-result modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_seq
  import matmul_seq_pkg::*;
#(
  parameter int N         = 2,
  parameter int DataWidth = 8,
  parameter int AccWidth  = acc_width(N, DataWidth)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  matmul_seq_if.slave bus
);

  localparam int              CNT_W    = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

  matmul_state_e state_q;
  matmul_state_e state_d;

  logic [CNT_W-1:0]     i_q;
  logic [CNT_W-1:0]     k_q;
  logic [DataWidth-1:0] a_mat [N][N];
  logic [DataWidth-1:0] b_mat [N][N];
  logic                 signed_q;
  logic                 accumulate_q;
  logic [AccWidth-1:0]  result_mat [N][N];
  logic [AccWidth-1:0]  mac_sum [N];
  logic [AccWidth-1:0]  mac_seed [N];
  logic [DataWidth-1:0] a_sel;

  logic accept;
  logic busy;
  logic last_k;
  logic last_i;

  assign accept = (state_q == IDLE) && bus.in_valid_i;
  assign busy   = (state_q == BUSY);
  assign last_k = (k_q == LAST_IDX);
  assign last_i = (i_q == LAST_IDX);

  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid_i) state_d = BUSY;
      BUSY:    if (last_i && last_k) state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row (i) and inner-product (k) counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      i_q <= '0;
      k_q <= '0;
    end else if (accept) begin
      i_q <= '0;
      k_q <= '0;
    end else if (busy) begin
      if (last_k) begin
        k_q <= '0;
        i_q <= last_i ? '0 : i_q + 1'b1;
      end else begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  // Operand and mode capture on input handshake
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      signed_q     <= 1'b0;
      accumulate_q <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mat[r][c] <= '0;
          b_mat[r][c] <= '0;
        end
      end
    end else if (accept) begin
      signed_q     <= bus.signed_i;
      accumulate_q <= bus.accumulate_i;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mat[r][c] <= bus.operand_a_i[elem_lsb(r, c, N, DataWidth) +: DataWidth];
          b_mat[r][c] <= bus.operand_b_i[elem_lsb(r, c, N, DataWidth) +: DataWidth];
        end
      end
    end
  end

  // A[i][k] is shared by every lane; each lane j takes B[k][j] and seeds
  // from C[i][j] when accumulating into the held result
  assign a_sel = a_mat[i_q][k_q];

  generate
    for (genvar j = 0; j < N; j++) begin : g_mac
      assign mac_seed[j] = accumulate_q ? result_mat[i_q][j] : '0;

      matmul_mac #(
        .DataWidth (DataWidth),
        .AccWidth  (AccWidth)
      ) u_mac (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (busy),
        .load_i   (k_q == '0),
        .signed_i (signed_q),
        .a_i      (a_sel),
        .b_i      (b_mat[k_q][j]),
        .seed_i   (mac_seed[j]),
        .sum_o    (mac_sum[j])
      );
    end
  endgenerate

  // Result row write-back on the last inner-product step of each row
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          result_mat[r][c] <= '0;
        end
      end
    end else if (busy && last_k) begin
      for (int j = 0; j < N; j++) begin
        result_mat[i_q][j] <= mac_sum[j];
      end
    end
  end

  // Pack the result register row-major onto the output bus
  always_comb begin
    bus.result_o = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        bus.result_o[elem_lsb(r, c, N, AccWidth) +: AccWidth] = result_mat[r][c];
      end
    end
  end

endmodule : matmul_seq

`default_nettype wire

// File: tb/tb_matmul_seq.sv
// ============================================================================
// Module      : tb_matmul_seq
// Description : Self-checking bench for matmul_seq with a plain-arithmetic
//               matrix model
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_seq;
  import matmul_seq_pkg::*;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int AW = 2 * DW + $clog2(N);
  localparam int AB = N * N * DW;
  localparam longint MASK = (longint'(1) << AW) - 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  matmul_seq_if #(.N(N), .DataWidth(DW), .AccWidth(AW)) bus ();

  matmul_seq #(.N(N), .DataWidth(DW), .AccWidth(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int     errors = 0;
  int     checks = 0;
  longint model_c [N][N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic longint elem_val(input logic [AB-1:0] m, input int r, input int c, input bit sgn);
    logic [DW-1:0] e;
    e = m[(r * N + c) * DW +: DW];
    if (sgn) return longint'($signed(e));
    return longint'(e);
  endfunction

  function automatic logic [63:0] res_elem(input int r, input int c);
    logic [AW-1:0] v;
    v = bus.result_o[(r * N + c) * AW +: AW];
    return 64'(v);
  endfunction

  // Reference: C = (acc ? C : 0) + A*B, wrapped to AW bits
  task automatic model_step(input logic [AB-1:0] a, input logic [AB-1:0] b, input bit sgn, input bit acc);
    longint nc [N][N];
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        longint s;
        s = acc ? model_c[r][c] : 0;
        for (int k = 0; k < N; k++) s += elem_val(a, r, k, sgn) * elem_val(b, k, c, sgn);
        nc[r][c] = s & MASK;
      end
    end
    model_c = nc;
  endtask

  task automatic run_op(input logic [AB-1:0] a, input logic [AB-1:0] b, input bit sgn,
                        input bit acc, input int hold, input string tag);
    int cycles;
    logic [N*N*AW-1:0] snap;
    check({tag, "_in_ready"}, 64'(bus.in_ready_o), 64'd1);
    bus.operand_a_i  = a;
    bus.operand_b_i  = b;
    bus.signed_i     = sgn;
    bus.accumulate_i = acc;
    bus.in_valid_i   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i   = 1'b0;
    bus.operand_a_i  = AB'($urandom);
    bus.operand_b_i  = AB'($urandom);
    bus.signed_i     = 1'($urandom);
    bus.accumulate_i = 1'($urandom);
    model_step(a, b, sgn, acc);
    cycles = 0;
    while (bus.out_valid_o !== 1'b1 && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    check({tag, "_latency"}, 64'(cycles), 64'(N * N));
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        check($sformatf("%s_c%0d%0d", tag, r, c), res_elem(r, c), 64'(model_c[r][c]));
    snap = bus.result_o;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid_i  = ~bus.in_valid_i;
      bus.operand_a_i = AB'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_stable"}, 64'(bus.result_o == snap), 64'd1);
      check({tag, "_hold_in_ready"}, 64'(bus.in_ready_o), 64'd0);
      check({tag, "_hold_out_valid"}, 64'(bus.out_valid_o), 64'd1);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check({tag, "_idle_ready"}, 64'(bus.in_ready_o), 64'd1);
    check({tag, "_idle_out_valid"}, 64'(bus.out_valid_o), 64'd0);
    check({tag, "_result_kept"}, 64'(bus.result_o == snap), 64'd1);
  endtask

  initial begin
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) model_c[r][c] = 0;
    rst              = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.out_ready_i  = 1'b0;
    bus.operand_a_i  = '0;
    bus.operand_b_i  = '0;
    bus.signed_i     = 1'b0;
    bus.accumulate_i = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_result", 64'(bus.result_o == '0), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic unsigned multiply
    run_op(32'h04030201, 32'h08070605, 1'b0, 1'b0, 0, "basic");
    check("basic_c00_const", res_elem(0, 0), 64'd19);
    check("basic_c01_const", res_elem(0, 1), 64'd22);
    check("basic_c10_const", res_elem(1, 0), 64'd43);
    check("basic_c11_const", res_elem(1, 1), 64'd50);

    // Accumulate onto the held result
    run_op(32'h04030201, 32'h08070605, 1'b0, 1'b1, 0, "accum");
    check("accum_c00_const", res_elem(0, 0), 64'd38);
    check("accum_c11_const", res_elem(1, 1), 64'd100);

    // Unsigned maximum
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 0, "umax");
    check("umax_c10_const", res_elem(1, 0), 64'd130050);

    // Signed vs unsigned interpretation of the same bits
    run_op(32'hFFFFFFFF, 32'h02020202, 1'b1, 1'b0, 0, "signed");
    check("signed_c01_const", res_elem(0, 1), 64'h1FFFC);
    run_op(32'hFFFFFFFF, 32'h02020202, 1'b0, 1'b0, 0, "unsigned");
    check("unsigned_c01_const", res_elem(0, 1), 64'd1020);

    // Long backpressure with in_valid toggling, then accumulate to prove no capture
    run_op(32'h04030201, 32'h08070605, 1'b0, 1'b0, 10, "bp");
    run_op(32'h04030201, 32'h08070605, 1'b0, 1'b1, 0, "bp_after");
    check("bp_after_c11_const", res_elem(1, 1), 64'd100);

    // Reset during BUSY step 2
    bus.operand_a_i  = 32'h04030201;
    bus.operand_b_i  = 32'h08070605;
    bus.signed_i     = 1'b0;
    bus.accumulate_i = 1'b1;
    bus.in_valid_i   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid_i   = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(bus.in_ready_o), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("midrst_result", 64'(bus.result_o == '0), 64'd1);
    #1;
    rst = 1'b0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) model_c[r][c] = 0;
    @(posedge clk); #1;
    run_op(32'h04030201, 32'h08070605, 1'b0, 1'b1, 0, "postrst");
    check("postrst_c00_const", res_elem(0, 0), 64'd19);
    check("postrst_c11_const", res_elem(1, 1), 64'd50);

    // Randomized operations
    for (int t = 0; t < 20; t++) begin
      run_op(AB'($urandom), AB'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_matmul_seq

`default_nettype wire

// File: doc/matmul_seq.md
# matmul_seq

Parametrised, sequential N×N integer matrix multiplier with valid/ready handshakes on both sides, selectable signed/unsigned arithmetic and an accumulate mode (C ← C + A·B). It replaces the fixed 2×2 uint8 combinational multiplier as the compute engine behind the course accelerator register interface. It trades throughput for area: one row of N multiply-accumulate units is reused over N·N cycles.

## Interface
- `N`, default 2: matrix dimension, ≥ 2.
- `DataWidth`, default 8: operand element width.
- `AccWidth`, default 2·DataWidth + $clog2(N): result element width. Results wrap modulo 2^AccWidth.
- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_valid_i` in 1: operand set valid.
- `in_ready_o` out 1: engine idle and able to accept an operand set.
- `operand_a_i` in N·N·DataWidth: matrix A, row-major. Element (r,c) is at bits [DataWidth·(r·N+c+1)−1 : DataWidth·(r·N+c)].
- `operand_b_i` in N·N·DataWidth: matrix B, same packing.
- `signed_i` in 1: 1 means two's-complement elements, 0 means unsigned. Sampled with the operands.
- `accumulate_i` in 1: 1 means C ← C + A·B using the held result, 0 means C ← A·B. Sampled with the operands.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `result_o` out N·N·AccWidth: matrix C, row-major, same packing with AccWidth elements.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - `in_ready_o`=1.
  - When `in_valid_i` is high, capture A, B, `signed_i` and `accumulate_i` into registers, clear counters row i=0 and k=0, then go to BUSY.
- BUSY, one step per cycle:
  - For every column j: acc[j] ← acc[j] + A[i][k]·B[k][j].
  - At k=0 the seed value is C[i][j] if accumulate is set, otherwise 0.
  - Products are computed in 2·DataWidth bits, sign- or zero-extended to AccWidth, then summed modulo 2^AccWidth.
  - When k=N−1, write acc[0..N−1] into row i of the result register, set k←0 and increment i.
  - When i=N−1 and k=N−1, go to DONE.
- DONE:
  - `out_valid_o`=1 and `result_o` is held stable.
  - When `out_ready_i` is high, return to IDLE.
  - The result register keeps its value after the handshake, so it can be accumulated into.
- `in_ready_o` is high only in IDLE. `in_valid_i` is ignored in BUSY and DONE, and operand inputs may change freely.
- `out_valid_o` is high only in DONE and does not depend combinationally on `out_ready_i`.
- During BUSY, `result_o` shows partially updated rows. Consumers must qualify it with `out_valid_o`.

## Timing
- Reset values:
  - state IDLE, so `in_ready_o`=1.
  - `out_valid_o`=0.
  - `result_o`=0.
  - all counters and accumulators 0.
- Latency: if the input handshake occurs on clock edge T, `out_valid_o` rises after edge T+N·N. For N=2 that is 4 cycles.
- Throughput: at most one operation per N·N+2 cycles (accept, N·N compute steps, output handshake).
- A DONE→IDLE transition and a new acceptance cannot share a cycle, because `in_ready_o` is 0 in DONE.
- Reset asserted mid-operation aborts immediately. The result register clears, so a following accumulate starts from 0.
- Unbounded backpressure (`out_ready_i` low) keeps the block in DONE with no state change.

## Structure
- Package `matmul_seq_pkg` holds:
  - the state enum `matmul_state_e` (IDLE, BUSY, DONE);
  - function `acc_width(n, w)` returning 2·w + $clog2(n);
  - index helper functions mapping (row, col, N) to a flat element index.
- Sub-module `matmul_mac`:
  - one DataWidth×DataWidth multiplier plus an AccWidth accumulator;
  - inputs are `signed_i`, a seed value and a load pulse;
  - instantiated N times in a generate loop.
- The top level contains the FSM, the i/k counters, the operand and result registers, and the element select muxes.

## Test plan
- Basic multiply. N=2, DataWidth=8, unsigned. A=[[1,2],[3,4]], B=[[5,6],[7,8]], accumulate=0. Required: C=[[19,22],[43,50]], `out_valid_o` rises 4 cycles after acceptance.
- Unsigned maximum. All elements of A and B = 255. Required: every C element = 130050, no overflow in 17 bits.
- Signed mode. A all 0xFF (−1), B all 0x02, signed=1. Required: every C element = −4, i.e. 0x1FFFC in 17 bits. The same operands with signed=0 give every element = 1020.
- Accumulate. Repeat the basic multiply operands with accumulate=1 immediately after the first result. Required: C=[[38,44],[86,100]].
- Backpressure. Hold `out_ready_i` low for 10 cycles in DONE and toggle `in_valid_i` during that time. Required: `result_o` stable, `in_ready_o`=0, no new capture. On release the block returns to IDLE with `in_ready_o`=1.
- Mid-operation reset. Pulse `rst_i` during BUSY step 2, then issue an accumulate operation with the basic multiply operands. Required: all outputs return to their reset values, and the result is [[19,22],[43,50]], not a doubled value.
